// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers frames from a scanned seven-segment display bus
module seg_scan_decoder #(
  parameter int DIG_NUM      = 6,
  parameter int STABLE_CYC   = 4,
  parameter int SCAN_TIMEOUT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIG_NUM-1:0]     sel,
  input  logic [7:0]             dig,
  output logic [4*DIG_NUM-1:0]   value,
  output logic [DIG_NUM-1:0]     dp,
  output logic                   valid,
  output logic                   err,
  output logic                   stalled
);
  localparam int SW = DIG_NUM + 8;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(SCAN_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, STALL} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] s1, s2, prv;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt;
  logic [DIG_NUM-1:0] ssel, hot, seen, seen_nxt, sdp, sdp_nxt;
  logic [4*DIG_NUM-1:0] sh, sh_nxt;
  logic [7:0] sdig;
  logic [3:0] nib;
  logic same, cap, att, multi, ok, e, wr, done, tout, stl, bad, bad_nxt;
  assign {ssel, sdig} = s2;
  assign same = s2 == prv;
  assign cnt_nxt = !same ? '0 : (cnt == CW'(STABLE_CYC)) ? cnt : cnt + 1'b1;
  // fires only on the step into STABLE_CYC-1, so a held pair is captured once
  assign cap = same && cnt_nxt == CW'(STABLE_CYC - 1) && cnt != CW'(STABLE_CYC - 1);
  assign hot = ~ssel;
  assign multi = (hot & (hot - 1'b1)) != '0;
  assign att = cap && !(&ssel);
  assign e = multi || !ok;
  assign wr = att && !e;
  assign seen_nxt = seen | (wr ? hot : '0);
  assign bad_nxt = bad | (att && e);
  assign done = att && (&seen_nxt);
  assign tout = tcnt == TW'(SCAN_TIMEOUT);
  assign stl = state == COLLECT && !att && tout;
  assign stalled = state == STALL;
  always_comb begin
    nib = '0;
    ok = 1'b1;
    case (sdig[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: ok = 1'b0;
    endcase
  end
  always_comb begin
    sh_nxt = sh;
    sdp_nxt = sdp;
    for (int i = 0; i < DIG_NUM; i++)
      if (wr && hot[i]) begin
        sh_nxt[4*i +: 4] = nib;
        sdp_nxt[i] = ~sdig[7];
      end
  end
  always_comb begin
    state_nxt = state;
    if (att) state_nxt = COLLECT;
    else if (stl) state_nxt = STALL;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      prv <= '1;
      cnt <= '0;
      tcnt <= '0;
      seen <= '0;
      bad <= 1'b0;
      sh <= '0;
      sdp <= '0;
      value <= '0;
      dp <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      s1 <= {sel, dig};
      s2 <= s1;
      prv <= s2;
      cnt <= cnt_nxt;
      tcnt <= att ? '0 : tout ? tcnt : tcnt + 1'b1;
      sh <= sh_nxt;
      sdp <= sdp_nxt;
      seen <= (done || stl) ? '0 : seen_nxt;
      bad <= (done || stl) ? 1'b0 : bad_nxt;
      err <= att && e;
      valid <= done && !bad_nxt;
      if (done && !bad_nxt) begin
        value <= sh_nxt;
        dp <= sdp_nxt;
      end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: random and directed scans checked against a frame-level model
module tb_seg_scan_decoder;
  logic clk = 1'b0, rst;
  logic [5:0] sel, dp;
  logic [7:0] dig;
  logic [23:0] value;
  logic valid, err, stalled;
  always #5 clk = ~clk;
  seg_scan_decoder #(.DIG_NUM(6), .STABLE_CYC(4), .SCAN_TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .sel(sel), .dig(dig), .value(value), .dp(dp),
    .valid(valid), .err(err), .stalled(stalled));
  int n_vec = 0, n_bad = 0, n_err = 0, e_err = 0;
  logic [29:0] got_q[$], exp_q[$];
  logic [7:0] codes[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] m_nib[6];
  logic [5:0] m_seen = '0, m_dp = '0, one = 6'b1;
  logic m_bad = 1'b0, m_stalled = 1'b0;
  logic [13:0] last = 14'h3fff;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (valid === 1'b1) got_q.push_back({dp, value});
    if (err === 1'b1) n_err++;
  end
  // a stable dwell on a lit digit is one capture: legal ones fill the frame, others poison it
  function automatic void model_capture(input logic [5:0] s, input logic [7:0] d);
    int zeros = 0, idx = 0, k = -1;
    logic [23:0] v;
    if (s == 6'h3f) return;
    m_stalled = 1'b0;
    for (int i = 0; i < 6; i++) if (!s[i]) begin zeros++; idx = i; end
    for (int j = 0; j < 16; j++) if (codes[j][6:0] == d[6:0]) k = j;
    if (zeros != 1 || k < 0) begin
      e_err++;
      m_bad = 1'b1;
    end else begin
      m_nib[idx] = k[3:0];
      m_dp[idx] = ~d[7];
      m_seen[idx] = 1'b1;
    end
    if (m_seen == 6'h3f) begin
      for (int i = 0; i < 6; i++) v[4*i +: 4] = m_nib[i];
      if (!m_bad) exp_q.push_back({m_dp, v});
      m_seen = '0;
      m_bad = 1'b0;
    end
  endfunction
  task automatic dwell(input logic [5:0] s, input logic [7:0] d, input int n);
    sel = s;
    dig = d;
    repeat (n) @(posedge clk);
    #1;
    if ({s, d} != last && n >= 8) model_capture(s, d);
    last = {s, d};
  endtask
  task automatic digit(input int i, input logic [23:0] v, input logic [5:0] dpm);
    logic [7:0] c;
    c = codes[v[4*i +: 4]];
    dwell(~(one << i), {~dpm[i], c[6:0]}, 10);
  endtask
  task automatic scan(input logic [23:0] v, input logic [5:0] dpm);
    for (int i = 0; i < 6; i++) digit(i, v, dpm);
  endtask
  task automatic checkpoint(input string tag);
    logic [29:0] g, x;
    dwell(6'h3f, (last == 14'h3fff) ? 8'hfe : 8'hff, 12);
    check({tag, "_nvalid"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      check({tag, "_frame"}, {2'b0, g}, {2'b0, x});
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_nerr"}, n_err, e_err);
    check({tag, "_stalled"}, {31'b0, stalled}, {31'b0, m_stalled});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] s;
    logic [7:0] d;
    int n, r;
    rst = 1'b1;
    sel = 6'h3f;
    dig = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", {8'b0, value}, 32'h0);
    check("rst_dp", {26'b0, dp}, 32'h0);
    check("rst_pulses", {30'b0, valid, err}, 32'h0);
    check("rst_stalled", {31'b0, stalled}, 32'h0);
    rst = 1'b0;
    scan(24'h12AB5F, 6'h00);
    checkpoint("t1");
    check("t1_value", {8'b0, value}, 32'h12AB5F);
    check("t1_dp", {26'b0, dp}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) dwell(~(one << (i - 1)), 8'hC0, 2);
      digit(i, 24'h3C9E74, 6'h00);
    end
    checkpoint("t2");
    check("t2_value", {8'b0, value}, 32'h3C9E74);
    dwell(6'b111110, 8'hFF, 10);
    scan(24'h654321, 6'h00);
    scan(24'hFEDCBA, 6'h2A);
    checkpoint("t3");
    check("t3_value", {8'b0, value}, 32'hFEDCBA);
    dwell(6'b111100, 8'hC0, 10);
    dwell(6'h3f, 8'hff, 50);
    checkpoint("t4");
    for (int i = 0; i < 3; i++) digit(i, 24'h999999, 6'h00);
    dwell(6'h3f, 8'hff, 260);
    m_seen = '0;
    m_bad = 1'b0;
    m_stalled = 1'b1;
    check("t5_stall_set", {31'b0, stalled}, 32'h1);
    dwell(6'b111110, 8'h78, 10);
    check("t5_stall_fall", {31'b0, stalled}, 32'h0);
    for (int i = 1; i < 6; i++) digit(i, 24'h000007, 6'h01);
    checkpoint("t5");
    check("t5_value", {8'b0, value}, 32'h000007);
    check("t5_dp", {26'b0, dp}, 32'h1);
    for (int i = 0; i < 4; i++) digit(i, 24'h111111, 6'h00);
    rst = 1'b1;
    #1;
    check("t6_rst_value", {8'b0, value}, 32'h0);
    check("t6_rst_out", {24'b0, dp, valid, err}, 32'h0);
    sel = 6'h3f;
    dig = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_seen = '0;
    m_bad = 1'b0;
    m_stalled = 1'b0;
    last = 14'h3fff;
    scan(24'hA5B6C7, 6'h10);
    checkpoint("t6");
    check("t6_value", {8'b0, value}, 32'hA5B6C7);
    for (int k = 0; k < 300; k++) begin
      do begin
        r = $urandom_range(0, 99);
        s = (r < 10) ? 6'h3f : (r < 17) ? 6'($urandom) : ~(one << $urandom_range(0, 5));
        d = codes[$urandom_range(0, 15)];
        d[7] = 1'($urandom);
        if ($urandom_range(0, 99) < 10) d = 8'($urandom);
      end while ({s, d} == last);
      n = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 2) : $urandom_range(8, 12);
      dwell(s, d, n);
      if (k % 50 == 49) checkpoint("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
